rename_reg_file: RTL and testbench

//  Architectural register file (x0..x31) with per-register rename tags.

---
 rtl/rename_reg_file.sv | 102 ++++++++++
 tb/tb_rename_reg_file.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// Architectural register file x0..x31 with per-register ROB rename tags.
// Operand lookups resolve through the register, the same-cycle commit, or a ROB readiness lookup.
module rename_reg_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               rename_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
  input  logic [4:0]               rs1_id,
  input  logic [4:0]               rs2_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  input  logic                     rob_rs1_ready,
  input  logic [31:0]              rob_rs1_val,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs2_val,
  output logic [31:0]              rs1_val,
  output logic                     rs1_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [31:0]              rs2_val,
  output logic                     rs2_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep
);

  logic [31:0]              regs [32];
  logic [ROB_WIDTH_BIT-1:0] dep  [32];
  logic [31:0]              busy;

  logic commit_en;
  logic rename_en;

  assign commit_en = (commit_reg_id != 5'd0);
  assign rename_en = (rename_reg_id != 5'd0) && !clear;

  // Entry 0 is only ever reset, so x0 reads as zero, idle, tag 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
        dep[i]  <= '0;
      end
      busy <= 32'd0;
    end else if (rdy_in) begin
      if (commit_en) begin
        regs[commit_reg_id] <= commit_val;
        if (dep[commit_reg_id] == commit_rob_id)
          busy[commit_reg_id] <= 1'b0;
      end
      // A rename of the committing register wins: busy stays set with the new tag.
      if (clear) begin
        busy <= 32'd0;
      end else if (rename_en) begin
        busy[rename_reg_id] <= 1'b1;
        dep[rename_reg_id]  <= rename_rob_id;
      end
    end
  end

  assign rob_rs1_id = dep[rs1_id];
  assign rob_rs2_id = dep[rs2_id];
  assign rs1_dep    = dep[rs1_id];
  assign rs2_dep    = dep[rs2_id];

  always_comb begin
    rs1_val     = 32'd0;
    rs1_has_dep = 1'b0;
    if (rs1_id == 5'd0) begin
      rs1_val = 32'd0;
    end else if (!busy[rs1_id]) begin
      rs1_val = regs[rs1_id];
    end else if (commit_en && (commit_rob_id == dep[rs1_id])) begin
      rs1_val = commit_val;
    end else if (rob_rs1_ready) begin
      rs1_val = rob_rs1_val;
    end else begin
      rs1_has_dep = 1'b1;
    end
  end

  always_comb begin
    rs2_val     = 32'd0;
    rs2_has_dep = 1'b0;
    if (rs2_id == 5'd0) begin
      rs2_val = 32'd0;
    end else if (!busy[rs2_id]) begin
      rs2_val = regs[rs2_id];
    end else if (commit_en && (commit_rob_id == dep[rs2_id])) begin
      rs2_val = commit_val;
    end else if (rob_rs2_ready) begin
      rs2_val = rob_rs2_val;
    end else begin
      rs2_has_dep = 1'b1;
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed scenarios plus randomized traffic against a register/tag model.
module tb_rename_reg_file;

  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;
  logic [RW-1:0] commit_rob_id;
  logic [4:0]    rename_reg_id;
  logic [RW-1:0] rename_rob_id;
  logic [4:0]    rs1_id, rs2_id;
  logic [RW-1:0] rob_rs1_id, rob_rs2_id;
  logic          rob_rs1_ready, rob_rs2_ready;
  logic [31:0]   rob_rs1_val, rob_rs2_val;
  logic [31:0]   rs1_val, rs2_val;
  logic          rs1_has_dep, rs2_has_dep;
  logic [RW-1:0] rs1_dep, rs2_dep;

  int checks = 0;
  int errors = 0;

  // reference: architectural values, pending flag and pending tag per register
  logic [31:0]   m_regs [32];
  bit            m_busy [32];
  logic [RW-1:0] m_dep  [32];

  rename_reg_file #(.ROB_WIDTH_BIT(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val), .commit_rob_id(commit_rob_id),
    .rename_reg_id(rename_reg_id), .rename_rob_id(rename_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
    .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
    .rs1_val(rs1_val), .rs1_has_dep(rs1_has_dep), .rs1_dep(rs1_dep),
    .rs2_val(rs2_val), .rs2_has_dep(rs2_has_dep), .rs2_dep(rs2_dep)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 0;
      m_dep[i]  = '0;
    end
  endtask

  task automatic model_clock();
    bit renamed_same;
    if (!rdy_in) return;
    renamed_same = (rename_reg_id == commit_reg_id) && !clear;
    if (commit_reg_id != 0) begin
      m_regs[commit_reg_id] = commit_val;
      if (m_dep[commit_reg_id] == commit_rob_id && !renamed_same)
        m_busy[commit_reg_id] = 0;
    end
    if (clear) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (rename_reg_id != 0) begin
      m_busy[rename_reg_id] = 1;
      m_dep[rename_reg_id]  = rename_rob_id;
    end
  endtask

  task automatic model_lookup(input logic [4:0] id, input logic ready, input logic [31:0] rval,
                              output logic [31:0] val, output logic hd, output logic [RW-1:0] tag);
    val = 32'd0; hd = 1'b0; tag = m_dep[id];
    if (id == 0) tag = '0;
    else if (!m_busy[id]) val = m_regs[id];
    else if (commit_reg_id != 0 && commit_rob_id == m_dep[id]) val = commit_val;
    else if (ready) val = rval;
    else hd = 1'b1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1; clear = 0;
    commit_reg_id = 0; commit_val = 0; commit_rob_id = 0;
    rename_reg_id = 0; rename_rob_id = 0;
    rob_rs1_ready = 0; rob_rs1_val = 0; rob_rs2_ready = 0; rob_rs2_val = 0;
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_clock();
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1;
    #7;
    model_reset();
    rst_in = 0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_id = 5; rs2_id = 31; #1;
    checks++; if (rs1_val !== 0 || rs1_has_dep !== 0) begin errors++;
      $display("FAIL reset_x5 val=%h dep=%b need 0/0", rs1_val, rs1_has_dep); end
    checks++; if (rs2_val !== 0 || rs2_has_dep !== 0) begin errors++;
      $display("FAIL reset_x31 val=%h dep=%b need 0/0", rs2_val, rs2_has_dep); end
    checks++; if (rob_rs1_id !== 0 || rob_rs2_id !== 0) begin errors++;
      $display("FAIL reset_rob_id got %0d/%0d need 0/0", rob_rs1_id, rob_rs2_id); end
    commit_reg_id = 0; commit_val = 32'h1234; commit_rob_id = 0;
    rename_reg_id = 0;
    cycle();
    rs1_id = 0; rob_rs1_ready = 1; rob_rs1_val = 32'hFFFF; #1;
    checks++; if (rs1_val !== 0 || rs1_has_dep !== 0) begin errors++;
      $display("FAIL x0_zero val=%h dep=%b need 0/0", rs1_val, rs1_has_dep); end
    rob_rs1_ready = 0;
  endtask

  task automatic test_rename_commit();
    rename_reg_id = 3; rename_rob_id = 2;
    rs1_id = 3; #1;
    checks++; if (rs1_has_dep !== 0 || rs1_val !== 0) begin errors++;
      $display("FAIL rename_not_visible dep=%b val=%h need 0/0", rs1_has_dep, rs1_val); end
    cycle();
    rs1_id = 3; #1;
    checks++; if (rs1_has_dep !== 1 || rs1_dep !== 2 || rs1_val !== 0) begin errors++;
      $display("FAIL rename_dep has=%b tag=%0d val=%h need 1/2/0", rs1_has_dep, rs1_dep, rs1_val); end
    commit_reg_id = 3; commit_rob_id = 2; commit_val = 32'hDEAD; #1;
    checks++; if (rs1_has_dep !== 0 || rs1_val !== 32'hDEAD) begin errors++;
      $display("FAIL commit_bypass has=%b val=%h need 0/dead", rs1_has_dep, rs1_val); end
    cycle();
    #1;
    checks++; if (rs1_has_dep !== 0 || rs1_val !== 32'hDEAD) begin errors++;
      $display("FAIL after_commit has=%b val=%h need 0/dead", rs1_has_dep, rs1_val); end
  endtask

  task automatic test_stale_commit();
    rename_reg_id = 4; rename_rob_id = 1; cycle();
    rename_reg_id = 4; rename_rob_id = 5; cycle();
    commit_reg_id = 4; commit_rob_id = 1; commit_val = 7; cycle();
    rs2_id = 4; #1;
    checks++; if (rs2_has_dep !== 1 || rs2_dep !== 5) begin errors++;
      $display("FAIL stale_commit has=%b tag=%0d need 1/5", rs2_has_dep, rs2_dep); end
    clear = 1; cycle();
    #1;
    checks++; if (rs2_has_dep !== 0 || rs2_val !== 7) begin errors++;
      $display("FAIL stale_value has=%b val=%h need 0/7", rs2_has_dep, rs2_val); end
  endtask

  task automatic test_commit_and_rename_same();
    rename_reg_id = 14; rename_rob_id = 9; cycle();
    commit_reg_id = 14; commit_rob_id = 9; commit_val = 32'hAB;
    rename_reg_id = 14; rename_rob_id = 11; cycle();
    rs1_id = 14; #1;
    checks++; if (rs1_has_dep !== 1 || rs1_dep !== 11) begin errors++;
      $display("FAIL commit_rename_same has=%b tag=%0d need 1/11", rs1_has_dep, rs1_dep); end
  endtask

  task automatic test_rob_resolve();
    rename_reg_id = 6; rename_rob_id = 3; cycle();
    rs1_id = 6; rob_rs1_ready = 1; rob_rs1_val = 32'h42; #1;
    checks++; if (rs1_val !== 32'h42 || rs1_has_dep !== 0 || rob_rs1_id !== 3) begin errors++;
      $display("FAIL rob_resolve val=%h has=%b id=%0d need 42/0/3", rs1_val, rs1_has_dep, rob_rs1_id); end
    rob_rs1_ready = 0; #1;
    checks++; if (rs1_has_dep !== 1 || rs1_val !== 0) begin errors++;
      $display("FAIL rob_not_ready has=%b val=%h need 1/0", rs1_has_dep, rs1_val); end
  endtask

  task automatic test_clear();
    rename_reg_id = 1; rename_rob_id = 6; cycle();
    rename_reg_id = 2; rename_rob_id = 7; cycle();
    rs1_id = 1; rs2_id = 2; #1;
    checks++; if (rs1_has_dep !== 1 || rs2_has_dep !== 1) begin errors++;
      $display("FAIL pre_clear has=%b/%b need 1/1", rs1_has_dep, rs2_has_dep); end
    clear = 1; commit_reg_id = 7; commit_rob_id = 0; commit_val = 9;
    rename_reg_id = 8; rename_rob_id = 4; cycle();
    #1;
    checks++; if (rs1_has_dep !== 0 || rs2_has_dep !== 0 || rs1_val !== 0) begin errors++;
      $display("FAIL clear_busy has=%b/%b val=%h need 0/0/0", rs1_has_dep, rs2_has_dep, rs1_val); end
    rs1_id = 7; rs2_id = 8; #1;
    checks++; if (rs1_val !== 9 || rs1_has_dep !== 0) begin errors++;
      $display("FAIL clear_commit val=%h has=%b need 9/0", rs1_val, rs1_has_dep); end
    checks++; if (rs2_has_dep !== 0) begin errors++;
      $display("FAIL clear_rename has=%b need 0", rs2_has_dep); end
  endtask

  task automatic test_stall();
    rename_reg_id = 11; rename_rob_id = 12; cycle();
    rdy_in = 0; rename_reg_id = 9; rename_rob_id = 9;
    commit_reg_id = 10; commit_rob_id = 0; commit_val = 32'h55; cycle();
    rdy_in = 0; clear = 1; cycle();
    rs1_id = 9; rs2_id = 10; #1;
    checks++; if (rs1_has_dep !== 0 || rs2_val !== 0) begin errors++;
      $display("FAIL stall_no_change has=%b val=%h need 0/0", rs1_has_dep, rs2_val); end
    rs1_id = 11; #1;
    checks++; if (rs1_has_dep !== 1 || rs1_dep !== 12) begin errors++;
      $display("FAIL stall_clear has=%b tag=%0d need 1/12", rs1_has_dep, rs1_dep); end
  endtask

  task automatic test_async_reset();
    rename_reg_id = 12; rename_rob_id = 2;
    commit_reg_id = 13; commit_rob_id = 0; commit_val = 32'h77; cycle();
    rs1_id = 12; rs2_id = 13; #1;
    checks++; if (rs1_has_dep !== 1 || rs2_val !== 32'h77) begin errors++;
      $display("FAIL pre_async has=%b val=%h need 1/77", rs1_has_dep, rs2_val); end
    #1 rst_in = 1; #1;
    checks++; if (rs1_has_dep !== 0 || rob_rs1_id !== 0 || rs2_val !== 0) begin errors++;
      $display("FAIL async_reset has=%b id=%0d val=%h need 0/0/0", rs1_has_dep, rob_rs1_id, rs2_val); end
    model_reset();
    @(negedge clk_in);
    rst_in = 0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_random();
    logic [31:0]   ev1, ev2;
    logic          eh1, eh2;
    logic [RW-1:0] et1, et2;
    for (int n = 0; n < 400; n++) begin
      rdy_in = ($urandom_range(9) != 0);
      clear  = ($urandom_range(19) == 0);
      commit_reg_id = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      commit_val    = $urandom;
      commit_rob_id = $urandom_range(1) ? m_dep[commit_reg_id] : RW'($urandom);
      rename_reg_id = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
      rename_rob_id = RW'($urandom);
      rs1_id = 5'($urandom); rs2_id = 5'($urandom);
      rob_rs1_ready = $urandom_range(1); rob_rs1_val = $urandom;
      rob_rs2_ready = $urandom_range(1); rob_rs2_val = $urandom;
      #1;
      model_lookup(rs1_id, rob_rs1_ready, rob_rs1_val, ev1, eh1, et1);
      model_lookup(rs2_id, rob_rs2_ready, rob_rs2_val, ev2, eh2, et2);
      checks++; if (rs1_val !== ev1 || rs1_has_dep !== eh1) begin errors++;
        $display("FAIL rnd_rs1 n=%0d x%0d val=%h has=%b need %h/%b", n, rs1_id, rs1_val, rs1_has_dep, ev1, eh1); end
      checks++; if (rs2_val !== ev2 || rs2_has_dep !== eh2) begin errors++;
        $display("FAIL rnd_rs2 n=%0d x%0d val=%h has=%b need %h/%b", n, rs2_id, rs2_val, rs2_has_dep, ev2, eh2); end
      checks++; if (rob_rs1_id !== et1 || rob_rs2_id !== et2) begin errors++;
        $display("FAIL rnd_rob_id n=%0d got %0d/%0d need %0d/%0d", n, rob_rs1_id, rob_rs2_id, et1, et2); end
      if (eh1) begin checks++; if (rs1_dep !== et1) begin errors++;
        $display("FAIL rnd_rs1_dep n=%0d got %0d need %0d", n, rs1_dep, et1); end end
      if (eh2) begin checks++; if (rs2_dep !== et2) begin errors++;
        $display("FAIL rnd_rs2_dep n=%0d got %0d need %0d", n, rs2_dep, et2); end end
      cycle();
    end
  endtask

  initial begin
    rs1_id = 0; rs2_id = 0;
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_commit_and_rename_same();
    test_rob_resolve();
    test_clear();
    test_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
